// File: rtl/id_ex_pipe_reg.sv
// ID/EX stage register: valid/ready flow control, optional skid entry,
// flush squash with zeroed control on bubbles, saturating event counters.
module id_ex_pipe_reg #(
    parameter int DATA_W = 133,
    parameter int CTRL_W = 12,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic in_acc;
    logic ld_main_in;
    logic ld_main_skid;
    logic ld_skid;
    logic stall_ev;
    logic flush_ev;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign in_acc    = in_valid && in_ready;
    assign stall_ev  = out_valid && !out_ready;
    assign flush_ev  = flush && (out_valid || in_valid);

    always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_acc) begin
                    state_nxt  = ONE;
                    ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_acc && out_ready) begin
                    ld_main_in = 1'b1;
                end else if (in_acc) begin
                    state_nxt = FULL;
                    ld_skid   = 1'b1;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_nxt    = ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // A flush kills held entries and drops any beat taken this cycle
        if (flush) begin
            state_nxt    = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state <= state_nxt;
            if (ld_main_in) begin
                main_data <= in_data;
            end else if (ld_main_skid) begin
                main_data <= skid_data;
            end
            if (state_nxt == EMPTY) begin
                main_ctrl <= '0;
            end else if (ld_main_in) begin
                main_ctrl <= in_ctrl;
            end else if (ld_main_skid) begin
                main_ctrl <= skid_ctrl;
            end
            if (ld_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= (state_nxt != FULL);
                end
            end
            assign in_ready = rdy_q;
        end else begin : g_noskid
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_ev && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID/EX pipeline stage register with valid/ready flow control, an optional two-entry skid buffer, flush support, and stall/flush event counters. It sits between decode and execute and carries a data payload (PC, immediate, operands, rd address) and a control payload (ALU and memory controls, write-back select, rd_wen). It adds back-pressure, bubble insertion and squash, which a plain per-cycle register does not provide. Control bits always read zero on a bubble, so execute never acts on a killed or empty slot.

## Interface
- DATA_W, 133, data payload width (PC 32 + imm 32 + rs1 32 + rs2 32 + rd 5)
- CTRL_W, 12, control payload width (ALU_src 1, ALU_ctrl 4, branch, MemWrite, jal, jalr, PMAItoReg 2, rd_wen)
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- CNT_W, 16, width of the saturating event counters

Ports:
- clk  in  1  single clock; all state updates on posedge clk
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode offers a beat
- in_ready  out  1  stage accepts a beat this cycle
- in_data  in  DATA_W  decode data payload
- in_ctrl  in  CTRL_W  decode control payload
- out_valid  out  1  execute-side beat valid
- out_ready  in  1  execute consumes the beat this cycle
- out_data  out  DATA_W  held data payload
- out_ctrl  out  CTRL_W  held control payload; all zeros whenever out_valid=0
- flush  in  1  squash all held entries and any beat offered this cycle
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (saturating)
- flush_cnt  out  CNT_W  flush cycles that killed at least one valid entry or offered beat (saturating)

## Operation
- Handshake: a beat transfers on an input when in_valid && in_ready, and on the output when out_valid && out_ready. Beat order is preserved.
- States for SKID=1: EMPTY (no entries), ONE (main entry valid), FULL (main and skid entries valid).
  - EMPTY: input accept -> ONE, and main loads the input.
  - ONE: accept && out_ready -> ONE, and main is replaced. Accept && !out_ready -> FULL, and skid loads the input. No accept && out_ready -> EMPTY.
  - FULL: in_ready=0. out_ready -> ONE, and main loads skid.
- in_ready for SKID=1 is a register, equal to (state != FULL). There is no combinational path from out_ready to in_ready.
- SKID=0: only EMPTY and ONE exist. in_ready = !out_valid || out_ready (combinational). Transitions are as above, with no FULL state.
- flush=1: next state is EMPTY from any state. An input beat offered in the same cycle is discarded. in_ready keeps its normal value, so a handshake may occur, but the beat is dropped.
- Bubble: when the next state is EMPTY, out_ctrl is registered as 0. out_data holds its last value, so its content is don't-care while invalid.
- Counters increment by 1 per qualifying cycle and saturate at 2^CNT_W-1. They do not wrap.
- stall_cnt counts in FULL as well as ONE.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on out_* after edge N.
- Throughput is 1 beat/cycle sustained when out_ready=1, for both SKID settings.
- With SKID=1, after out_ready deasserts, in_ready falls on the following edge. The one beat accepted in that cycle lands in skid and is not lost.
- Reset (async assert, sync-safe release) sets:
  - out_valid=0, out_ctrl=0, out_data=0
  - skid contents=0, state EMPTY, in_ready=1
  - stall_cnt=0, flush_cnt=0
- Reset mid-transfer drops all entries. No beat is emitted after reset release until a new input is accepted.
- flush together with out_ready in FULL: both entries are killed; the output handshake in that cycle still counts as consumed by execute.
- Counters reflect events up to the previous edge (registered outputs).

## Test plan
- Reset then stream: rst_n low 3 cycles, then 8 beats with in_data=i and in_ctrl=12'h001, out_ready=1 -> out_valid from cycle 1 after the first accept, data 0..7 in order, in_ready stays 1, stall_cnt=0.
- Back-pressure (SKID=1): stream beats 1,2,3 with out_ready=0 from the second output cycle -> state FULL holding 1 (main) and 2 (skid), in_ready=0, beat 3 is held at the input. After out_ready=1, the output is 1,2,3 with no loss. stall_cnt equals the number of out_ready=0 cycles.
- SKID=0 stall: same stimulus -> in_ready=0 in the same cycle as out_ready=0 while out_valid=1, and no beat is lost.
- Flush in FULL with a beat offered: flush=1 for one cycle -> out_valid=0 and out_ctrl=0 next cycle, the offered beat never appears, flush_cnt=1. Flush when EMPTY with in_valid=0 -> flush_cnt stays 1.
- Counter saturation with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and remains 15.
- Async reset mid-stream: assert rst_n low between edges while FULL -> outputs go to reset values immediately; after release the first output is the first new beat.
